pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB hold/bubble controls.

---
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. It produces the hold
// and bubble controls for PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB.
// It does three jobs:
//   - inserts a one-cycle bubble on a load-use hazard
//   - discards the wrong-path fetch on an ID-stage redirect
//   - freezes the whole pipe while a data-memory access is outstanding
// It also keeps saturating counters of stall cycles and flush cycles.
// Ports:
//   clk, rst (async, active-low)
//   ifid_rs, ifid_rt, ifid_uses_rt        : source operands of the ID instruction
//   idexe_dmrd, idexe_rd, idexe_rfwr      : load/destination info of the EX instruction
//   id_redirect                           : taken branch/jump resolved in ID
//   mem_req, mem_ack                      : DM access handshake of the MEM instruction
//   pc_stall, ifid_stall, ifid_flush,
//   idexe_stall, idexe_flush,
//   exemem_stall, memwb_flush             : pipeline register controls
//   mem_timeout                           : sticky DM timeout flag
//   stall_cnt, flush_cnt                  : saturating event counters
module pipe_hazard_ctrl #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic [3:0]       idexe_dmrd,
   input  logic [4:0]       idexe_rd,
   input  logic             idexe_rfwr,
   input  logic             id_redirect,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idexe_stall,
   output logic             idexe_flush,
   output logic             exemem_stall,
   output logic             memwb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     state;
   state_t     stateNext;
   logic [7:0] waitCnt;
   logic [7:0] waitNext;
   logic       loadUse;
   logic       memHold;
   logic       freeze;
   logic       luStall;
   logic       redirFlush;
   logic       timeoutSet;

   // A load in EX whose destination is a source of the ID instruction.
   // Register 0 never creates a hazard.
   assign loadUse = (idexe_dmrd != 4'd0) && idexe_rfwr && (idexe_rd != 5'd0) &&
                    ((idexe_rd == ifid_rs) || (ifid_uses_rt && (idexe_rd == ifid_rt)));

   assign memHold = mem_req && !mem_ack;

   // Next-state and control decode. The priority is memory freeze, then
   // load-use, then redirect.
   // When a redirect coincides with a load-use hazard, only the stall is
   // taken. The branch re-resolves next cycle with valid operands.
   always_comb begin
      stateNext  = state;
      waitNext   = waitCnt;
      timeoutSet = 1'b0;
      freeze     = 1'b0;
      luStall    = 1'b0;
      redirFlush = 1'b0;
      case (state)
         RUN: begin
            if (memHold) begin
               freeze    = 1'b1;
               stateNext = MEM_WAIT;
               waitNext  = 8'd1;
            end else if (loadUse) begin
               luStall = 1'b1;
            end else if (id_redirect) begin
               redirFlush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               stateNext = RUN;
               waitNext  = 8'd0;
            end else if (waitCnt < WAIT_MAX) begin
               freeze   = 1'b1;
               waitNext = waitCnt + 8'd1;
            end else begin
               freeze     = 1'b1;
               stateNext  = ERROR;
               timeoutSet = 1'b1;
            end
         end
         ERROR: begin
            freeze = 1'b1;
         end
         default: begin
            stateNext = RUN;
            waitNext  = 8'd0;
         end
      endcase
   end

   // Controls are gated by reset so that an asynchronous reset silences them
   // immediately, even with hazard-looking inputs present.
   assign pc_stall     = rst & (freeze | luStall);
   assign ifid_stall   = rst & (freeze | luStall);
   assign ifid_flush   = rst & redirFlush;
   assign idexe_stall  = rst & freeze;
   assign idexe_flush  = rst & luStall;
   assign exemem_stall = rst & freeze;
   assign memwb_flush  = rst & freeze;

   // State, wait counter, sticky timeout flag and saturating event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         waitCnt     <= 8'd0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitNext;
         if (timeoutSet) begin
            mem_timeout <= 1'b1;
         end
         if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl.
// Each stimulus cycle pushes its expected control vector and timeout flag
// into a scoreboard queue. The entry is popped and compared on the falling
// edge of the same cycle. Counters are checked against constants.
// The DUT is built with a short memory timeout and narrow counters so that
// the timeout and saturation boundaries are reachable.
module tb_pipe_hazard_ctrl;

   localparam int WAIT_MAX = 4;
   localparam int CW       = 4;

   // Control vector order:
   // {pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush, exemem_stall, memwb_flush}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100100;
   localparam logic [6:0] RD   = 7'b0010000;
   localparam logic [6:0] FRZ  = 7'b1101011;

   typedef struct {
      string      tag;
      logic [6:0] ctrl;
      logic       timeout;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [4:0]    ifid_rs;
   logic [4:0]    ifid_rt;
   logic          ifid_uses_rt;
   logic [3:0]    idexe_dmrd;
   logic [4:0]    idexe_rd;
   logic          idexe_rfwr;
   logic          id_redirect;
   logic          mem_req;
   logic          mem_ack;
   logic          pc_stall;
   logic          ifid_stall;
   logic          ifid_flush;
   logic          idexe_stall;
   logic          idexe_flush;
   logic          exemem_stall;
   logic          memwb_flush;
   logic          mem_timeout;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
   logic [6:0]    obsCtrl;

   exp_t sb[$];
   int   compared;
   int   mismatched;

   pipe_hazard_ctrl #(
      .MEM_WAIT_MAX(WAIT_MAX),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ifid_rs     (ifid_rs),
      .ifid_rt     (ifid_rt),
      .ifid_uses_rt(ifid_uses_rt),
      .idexe_dmrd  (idexe_dmrd),
      .idexe_rd    (idexe_rd),
      .idexe_rfwr  (idexe_rfwr),
      .id_redirect (id_redirect),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .ifid_flush  (ifid_flush),
      .idexe_stall (idexe_stall),
      .idexe_flush (idexe_flush),
      .exemem_stall(exemem_stall),
      .memwb_flush (memwb_flush),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   assign obsCtrl = {pc_stall, ifid_stall, ifid_flush, idexe_stall,
                     idexe_flush, exemem_stall, memwb_flush};

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guards against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, need finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs and queues the outputs expected for that cycle.
   task automatic applyStimulus(input string tag,
                                input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                input logic [3:0] dmrd, input logic [4:0] rd, input logic rfwr,
                                input logic redir, input logic req, input logic ack,
                                input logic [6:0] expCtrl, input logic expTo);
      exp_t e;
      ifid_rs      = rs;
      ifid_rt      = rt;
      ifid_uses_rt = usesRt;
      idexe_dmrd   = dmrd;
      idexe_rd     = rd;
      idexe_rfwr   = rfwr;
      id_redirect  = redir;
      mem_req      = req;
      mem_ack      = ack;
      e.tag        = tag;
      e.ctrl       = expCtrl;
      e.timeout    = expTo;
      sb.push_back(e);
      // Pop on the falling edge, then advance past the next rising edge.
      @(negedge clk);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({e.tag, "_ctrl"}, 32'(obsCtrl), 32'(e.ctrl));
         checkOutput({e.tag, "_timeout"}, 32'(mem_timeout), 32'(e.timeout));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      // Reset is held while hazard-looking inputs are present.
      rst          = 1'b0;
      ifid_rs      = 5'd8;
      ifid_rt      = 5'd0;
      ifid_uses_rt = 1'b0;
      idexe_dmrd   = 4'd1;
      idexe_rd     = 5'd8;
      idexe_rfwr   = 1'b1;
      id_redirect  = 1'b1;
      mem_req      = 1'b1;
      mem_ack      = 1'b0;
      #2;
      checkOutput("rst_ctrl", 32'(obsCtrl), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      checkOutput("rst_timeout", 32'(mem_timeout), 32'd0);
      mem_req     = 1'b0;
      id_redirect = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // A load into $8 followed by a use of $8 stalls for exactly one cycle.
      applyStimulus("t1_lu",   5'd8, 5'd0, 1'b0, 4'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b0);
      applyStimulus("t1_gone", 5'd8, 5'd0, 1'b0, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      checkOutput("t1_stall_cnt", 32'(stall_cnt), 32'd1);

      // Cases on the rt port, register 0, and non-writing or non-load EX.
      applyStimulus("t2_rt_unused", 5'd3, 5'd8, 1'b0, 4'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      applyStimulus("t2_rt_used",   5'd3, 5'd8, 1'b1, 4'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, LU,   1'b0);
      applyStimulus("t2_rd0",       5'd0, 5'd0, 1'b1, 4'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      applyStimulus("t2_nowr",      5'd8, 5'd0, 1'b0, 4'd1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      applyStimulus("t2_noload",    5'd8, 5'd0, 1'b0, 4'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      checkOutput("t2_stall_cnt", 32'(stall_cnt), 32'd2);

      // A redirect alone flushes IF_ID. A redirect during load-use only stalls.
      applyStimulus("t3_redir",    5'd1, 5'd2, 1'b1, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, RD, 1'b0);
      checkOutput("t3_flush_cnt", 32'(flush_cnt), 32'd1);
      applyStimulus("t3_redir_lu", 5'd9, 5'd0, 1'b0, 4'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, LU, 1'b0);
      checkOutput("t3_stall_cnt", 32'(stall_cnt), 32'd3);
      checkOutput("t3_flush_cnt2", 32'(flush_cnt), 32'd1);

      // A DM access acknowledged in the same cycle does not freeze.
      applyStimulus("t4_same_ack", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NONE, 1'b0);

      // A DM access acked after 3 cycles freezes 3 cycles. Hazards seen while
      // frozen are ignored. Once RUN resumes, the held load-use is taken.
      applyStimulus("t4_c0", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
      applyStimulus("t4_c1", 5'd5, 5'd0, 1'b0, 4'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FRZ,  1'b0);
      applyStimulus("t4_c2", 5'd5, 5'd0, 1'b0, 4'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ,  1'b0);
      applyStimulus("t4_c3", 5'd5, 5'd0, 1'b0, 4'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, NONE, 1'b0);
      checkOutput("t4_stall_cnt", 32'(stall_cnt), 32'd6);
      applyStimulus("t4_resume_lu", 5'd5, 5'd0, 1'b0, 4'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0);
      checkOutput("t4_stall_cnt2", 32'(stall_cnt), 32'd7);

      // The stall counter saturates at all-ones.
      for (int i = 0; i < 10; i++) begin
         applyStimulus("sat_lu", 5'd5, 5'd0, 1'b0, 4'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0);
      end
      checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);

      // An async reset in the middle of MEM_WAIT silences the outputs at once.
      applyStimulus("t6_c0", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t6_c1", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t6_rst_ctrl", 32'(obsCtrl), 32'd0);
      checkOutput("t6_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("t6_rst_flush_cnt", 32'(flush_cnt), 32'd0);
      mem_req = 1'b0;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("t6_idle", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 1'b0);
      checkOutput("t6_stall_cnt", 32'(stall_cnt), 32'd0);

      // With the limit at 4, an access that is never acked times out. After
      // that the pipe stays frozen and a late ack has no effect.
      applyStimulus("t5_c0", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t5_c1", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t5_c2", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t5_c3", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t5_c4", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      applyStimulus("t5_c5", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b1);
      applyStimulus("t5_late_ack", 5'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FRZ, 1'b1);
      applyStimulus("t5_err_lu",   5'd7, 5'd0, 1'b0, 4'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 1'b1);

      // Only reset leaves ERROR.
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t5_rst_ctrl", 32'(obsCtrl), 32'd0);
      checkOutput("t5_rst_timeout", 32'(mem_timeout), 32'd0);

      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
